// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one synchronous-read fetch per
// cycle under a credit rule, and queues returning words in a 2-entry FIFO for decode.
module fetch_ctrl #(
   parameter int unsigned          MEM_DEPTH     = 16,
   parameter logic [MEM_DEPTH-1:0] PC_START_ADDR = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic                 imem_en,
   output logic [MEM_DEPTH-1:0] imem_addr,
   input  logic [31:0]          imem_rdata,
   input  logic                 redirect_valid,
   input  logic [MEM_DEPTH-1:0] redirect_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [31:0]          inst_data,
   output logic [MEM_DEPTH-1:0] inst_pc
);

   logic [MEM_DEPTH-1:0] pc_q, pc_d;
   logic [MEM_DEPTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                 inflight_q, inflight_d;
   logic [31:0]          fifo_data_q [2];
   logic [31:0]          fifo_data_d [2];
   logic [MEM_DEPTH-1:0] fifo_pc_q [2];
   logic [MEM_DEPTH-1:0] fifo_pc_d [2];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;

   logic                 pop;
   logic                 push;
   logic                 issue;
   logic [2:0]           credit;
   logic [MEM_DEPTH-1:0] redirect_tgt;

   // Credit counts queued entries plus the response still in flight, so every
   // issued fetch is guaranteed a FIFO slot when its data returns.
   always_comb begin
      pop          = (count_q != 2'd0) & inst_ready;
      credit       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue        = !reset & !redirect_valid & (credit < 3'd2);
      push         = inflight_q & !redirect_valid;
      redirect_tgt = redirect_pc & ~MEM_DEPTH'(3);
   end

   assign imem_en    = issue;
   assign imem_addr  = pc_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_data  = fifo_data_q[rd_ptr_q];
   assign inst_pc    = fifo_pc_q[rd_ptr_q];

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      fifo_data_d   = fifo_data_q;
      fifo_pc_d     = fifo_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (redirect_valid) begin
         pc_d       = redirect_tgt;
         inflight_d = 1'b0;
         count_d    = 2'd0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
      end else begin
         if (push) begin
            fifo_data_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d              = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
         if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + MEM_DEPTH'(4);
         end else begin
            inflight_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= PC_START_ADDR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fifo_data_q   <= fifo_data_d;
         fifo_pc_q     <= fifo_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected PC streams are queued when reset/redirect
// stimulus is applied and checked against every word presented to decode.
module tb_fetch_ctrl;

   localparam int unsigned AW = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   inst_data;
   logic [AW-1:0] inst_pc;

   logic          w_imem_en;
   logic [AW-1:0] w_imem_addr;
   logic [31:0]   w_imem_rdata;
   logic          w_redirect_valid = 1'b0;
   logic [AW-1:0] w_redirect_pc = '0;
   logic          w_inst_valid;
   logic          w_inst_ready = 1'b1;
   logic [31:0]   w_inst_data;
   logic [AW-1:0] w_inst_pc;

   fetch_ctrl #(.MEM_DEPTH(AW), .PC_START_ADDR(16'h0000)) u_dut (
      .clock(clock), .reset(reset),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   fetch_ctrl #(.MEM_DEPTH(AW), .PC_START_ADDR(16'hFFF8)) u_wrap (
      .clock(clock), .reset(reset),
      .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
      .inst_data(w_inst_data), .inst_pc(w_inst_pc)
   );

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   // One-cycle read latency; data is junk whenever no request was made.
   always @(posedge clock) begin
      imem_rdata   <= imem_en ? mem_word(imem_addr) : 32'hDEADBEEF;
      w_imem_rdata <= w_imem_en ? mem_word(w_imem_addr) : 32'hDEADBEEF;
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [AW-1:0] exp_q [$];
   logic [AW-1:0] wexp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refill(input logic [AW-1:0] start);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(start + AW'(i * 4));
   endtask

   task automatic wrefill(input logic [AW-1:0] start);
      wexp_q.delete();
      for (int i = 0; i < 48; i++) wexp_q.push_back(start + AW'(i * 4));
   endtask

   task automatic step(input logic rst, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
      @(posedge clock);
      #1;
      reset          = rst;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clock);
      if (inst_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underflow: observed pc %0h expected no instruction", inst_pc);
         end else begin
            check("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
            check("inst_data", inst_data, mem_word(exp_q[0]));
            if (rdy && !rst) void'(exp_q.pop_front());
         end
      end
      if (w_inst_valid === 1'b1) begin
         if (wexp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL wrap_underflow: observed pc %0h expected no instruction", w_inst_pc);
         end else begin
            check("wrap_inst_pc", 32'(w_inst_pc), 32'(wexp_q[0]));
            check("wrap_inst_data", w_inst_data, mem_word(wexp_q[0]));
            if (!rst) void'(wexp_q.pop_front());
         end
      end
      if (rst) begin
         refill(16'h0000);
         wrefill(16'hFFF8);
      end else if (rv) begin
         refill(rpc & ~AW'(3));
      end
   endtask

   initial begin
      reset          = 1'b1;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check("rst_imem_en", 32'(imem_en), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", 32'(inst_pc), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'h0000);
      check("rst_wrap_addr", 32'(w_imem_addr), 32'hFFF8);

      // cycle 0..4: startup and steady state
      step(1'b0, 1'b1, 1'b0, '0);
      check("c0_en", 32'(imem_en), 32'd1);
      check("c0_addr", 32'(imem_addr), 32'h0000);
      check("c0_valid", 32'(inst_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("c1_en", 32'(imem_en), 32'd1);
      check("c1_addr", 32'(imem_addr), 32'h0004);
      check("c1_valid", 32'(inst_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("c2_valid", 32'(inst_valid), 32'd1);
      check("c2_en", 32'(imem_en), 32'd1);
      for (int c = 3; c <= 4; c++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         check("steady_en", 32'(imem_en), 32'd1);
      end

      // cycles 5..8: backpressure, FIFO fills and issue stops
      for (int c = 5; c <= 8; c++) begin
         step(1'b0, 1'b0, 1'b0, '0);
         check("stall_en", 32'(imem_en), 32'd0);
         check("stall_valid", 32'(inst_valid), 32'd1);
      end
      step(1'b0, 1'b1, 1'b0, '0);
      check("resume_en", 32'(imem_en), 32'd1);
      check("resume_addr", 32'(imem_addr), 32'h0014);
      for (int c = 10; c <= 13; c++) step(1'b0, 1'b1, 1'b0, '0);

      // redirect to 0x0100
      step(1'b0, 1'b1, 1'b1, 16'h0100);
      check("redir_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("redir_n1_en", 32'(imem_en), 32'd1);
      check("redir_n1_addr", 32'(imem_addr), 32'h0100);
      check("redir_n1_valid", 32'(inst_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("redir_n2_valid", 32'(inst_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("redir_n3_valid", 32'(inst_valid), 32'd1);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, '0);

      // misaligned redirect target
      step(1'b0, 1'b1, 1'b1, 16'h0103);
      check("mis_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("mis_addr", 32'(imem_addr), 32'h0100);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, '0);

      // back-to-back redirects: last one wins
      step(1'b0, 1'b1, 1'b1, 16'h0200);
      check("b2b_first_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b1, 16'h0300);
      check("b2b_second_en", 32'(imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("b2b_addr", 32'(imem_addr), 32'h0300);
      check("b2b_en", 32'(imem_en), 32'd1);
      step(1'b0, 1'b1, 1'b0, '0);
      check("b2b_n2_valid", 32'(inst_valid), 32'd0);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, '0);

      // stall one cycle so data is queued with a fetch in flight, then reset
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check("midrst_en", 32'(imem_en), 32'd0);
      check("midrst_wrap_en", 32'(w_imem_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("postrst_valid", 32'(inst_valid), 32'd0);
      check("postrst_en", 32'(imem_en), 32'd1);
      check("postrst_addr", 32'(imem_addr), 32'h0000);
      check("postrst_wrap_valid", 32'(w_inst_valid), 32'd0);
      check("postrst_wrap_addr", 32'(w_imem_addr), 32'hFFF8);
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
